mips32_mem_arbiter: RTL and testbench
=====================================

// Module: mips32_mem_arbiter
// PURPOSE
//  Arbitrates one single-ported instruction/data memory between two requesters in the mips32 core.
//  The requesters are the IF stage (instruction reads) and the MEM stage (LW reads, SW writes).
//  Memory side uses a req/ack handshake with variable wait states.
//  Arbitration is data-priority with a starvation guard for fetch, plus an ack timeout that reports an error.
// PARAMETERS
//  AW          10   word-address width (1024-word memory)
//  DW          32   data width
//  STARVE_MAX  2    consecutive contended D grants before I is forced; must be >=1
//  TIMEOUT     255  max ACCESS cycles without m_ack; 0 = no timeout
// PORTS
//  clk1     in   1   single clock, all state on posedge
//  rst_n    in   1   asynchronous active-low reset
//  i_req    in   1   fetch request; held with i_addr until i_done
//  i_addr   in   AW  fetch word address
//  i_rdata  out  DW  fetched word, valid while i_done=1, held after
//  i_done   out  1   one-cycle completion pulse, fetch
//  d_req    in   1   data request; held with d_we/d_addr/d_wdata until d_done
//  d_we     in   1   1=store, 0=load
//  d_addr   in   AW  data word address
//  d_wdata  in   DW  store data
//  d_rdata  out  DW  load data, valid while d_done=1, held after
//  d_done   out  1   one-cycle completion pulse, data
//  err      out  1   high with *_done when that access timed out
//  m_req    out  1   memory request
//  m_we     out  1   memory write enable
//  m_addr   out  AW  memory address
//  m_wdata  out  DW  memory write data
//  m_rdata  in   DW  memory read data, valid when m_ack=1
//  m_ack    in   1   memory completion, sampled only while m_req=1
//  owner_d  out  1   1 = current/last grant is the data port
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, starve_cnt=0, tmo_cnt=0. All outputs are registered.
//  Reset mid-access: m_req drops immediately; no done is issued; the aborted request is not resumed.
//  FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE:
//    - No req: stay in IDLE.
//    - Both req: grant I if starve_cnt==STARVE_MAX, else grant D.
//    - One req: grant that port.
//    - On grant, latch addr/we/wdata into m_*, set m_req=1, set owner_d, go to ACCESS.
//   ACCESS:
//    - m_* are held stable.
//    - m_ack=1: m_req<=0, capture m_rdata into owner's rdata (reads only), owner's done<=1, go to DONE.
//    - TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 without ack: m_req<=0, done<=1, err<=1, rdata unchanged, go to DONE.
//   DONE:
//    - done/err high for exactly this cycle; no arbitration.
//    - Next state IDLE; done and err return to 0.
//  Requester rule: a req seen in IDLE is a new request. A requester must drop req or present its next
//   request on the edge where it samples done.
//  Latency: req high in cycle 0 -> m_req in cycle 1 -> ack in cycle k>=1 -> done in cycle k+1.
//   Minimum is 3 cycles per access, one idle cycle between accesses.
//  starve_cnt: +1 (saturating at STARVE_MAX) when D is granted while i_req=1. Cleared when I is granted.
//   Unchanged when D is granted with i_req=0.
//  tmo_cnt: cleared on entry to ACCESS; +1 each ACCESS cycle without ack.
//  Writes: m_we=1 and m_wdata=d_wdata; d_rdata keeps its previous value. I port never writes.
//  m_ack outside ACCESS is ignored.
//  Address/data changes by a requester during ACCESS have no effect; values are latched at grant.
// TESTING
//  1. i_req addr 0, ack 1 cycle after m_req, m_rdata=32'h2801000a
//     -> i_done pulses once, i_rdata=32'h2801000a, d_done=0, err=0.
//  2. i_req and d_req held continuously, STARVE_MAX=2, ack immediate
//     -> grant order D,D,I,D,D,I (owner_d 1,1,0,1,1,0).
//  3. d_we=1 addr 5 wdata 32'h1E, ack after 3 wait cycles
//     -> m_we=1, m_addr=5, m_wdata=32'h1E stable for 4 cycles, d_done once, d_rdata unchanged.
//  4. TIMEOUT=8, d read, m_ack never asserted
//     -> m_req falls after 8 ACCESS cycles, d_done=1 and err=1 for one cycle, then IDLE.
//  5. rst_n low during ACCESS -> m_req=0 asynchronously, no done.
//     After release, i_req is serviced normally and starve_cnt=0.
//  6. m_ack tied 1, 5 back-to-back d loads -> exactly 5 d_done pulses, 3 cycles apart, correct data each.

Source files
------------

// File: rtl/mips32_mem_arbiter_if.sv
// Bundles the fetch port, data port and memory port of the mips32 memory arbiter.
// master = the arbiter itself; slave = requesters plus memory.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  // Handshakes: i_req/d_req are levels held with their payload until the matching
  // one-cycle *_done pulse; m_req is held with m_we/m_addr/m_wdata stable until
  // m_ack is sampled high (or the access times out), and m_ack is ignored otherwise.
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          err;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          owner_d;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_done, d_rdata, d_done, err,
           m_req, m_we, m_addr, m_wdata, owner_d
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_done, d_rdata, d_done, err,
           m_req, m_we, m_addr, m_wdata, owner_d
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for the mips32 core: data port has priority, fetch is
// forced after STARVE_MAX contended data grants, and a stuck access times out with err.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  mips32_mem_arbiter_if.master bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam bit            TMO_EN     = (TIMEOUT != 0);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          grant_i;

  // Fetch wins only when alone or when the data port has starved it long enough.
  always_comb grant_i = bus.i_req && (!bus.d_req || starve_cnt == STARVE_TOP);

  assign dbg_state = state;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      bus.i_rdata <= '0;
      bus.i_done  <= 1'b0;
      bus.d_rdata <= '0;
      bus.d_done  <= 1'b0;
      bus.err     <= 1'b0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.owner_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            bus.m_req <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ACCESS;
            if (grant_i) begin
              bus.owner_d <= 1'b0;
              bus.m_we    <= 1'b0;
              bus.m_addr  <= bus.i_addr;
              bus.m_wdata <= '0;
              starve_cnt  <= '0;
            end else begin
              bus.owner_d <= 1'b1;
              bus.m_we    <= bus.d_we;
              bus.m_addr  <= bus.d_addr;
              bus.m_wdata <= bus.d_wdata;
              if (bus.i_req && starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          if (bus.m_ack) begin
            bus.m_req <= 1'b0;
            state     <= DONE;
            if (bus.owner_d) begin
              bus.d_done <= 1'b1;
              if (!bus.m_we) bus.d_rdata <= bus.m_rdata;
            end else begin
              bus.i_done  <= 1'b1;
              bus.i_rdata <= bus.m_rdata;
            end
          end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
            // Timed-out access completes with err and leaves the read data untouched.
            bus.m_req <= 1'b0;
            bus.err   <= 1'b1;
            state     <= DONE;
            if (bus.owner_d) bus.d_done <= 1'b1;
            else             bus.i_done <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.i_done <= 1'b0;
          bus.d_done <= 1'b0;
          bus.err    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: memory responder, requester drivers, scoreboard
// monitor with a spec-level arbitration/latency model, directed cases and random traffic.
module tb_mips32_mem_arbiter;
  localparam int AW         = 10;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 2;
  localparam int TIMEOUT    = 8;
  localparam int DEPTH      = 1 << AW;

  logic       clk1  = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- shared state ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW:0]   i_exp_q[$];
  logic [DW:0]   d_exp_q[$];
  logic [DW-1:0] d_last;

  int resp_mode = 0;  // 0 = random waits, 1 = never ack, 2 = ack tied high
  int wait_min  = 0;
  int wait_max  = 0;

  logic grant_log[$];
  int   done_log[$];
  int   last_acc_len = 0;
  logic last_err     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int wait_left;
    wait_left = 0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk1);
      #2;
      if (!bus.m_req) begin
        bus.m_ack   = (resp_mode == 2);
        bus.m_rdata = $urandom;
        wait_left   = $urandom_range(wait_max, wait_min);
      end else if (resp_mode == 1) begin
        bus.m_ack = 1'b0;
      end else if (resp_mode == 2 || wait_left == 0) begin
        bus.m_ack = 1'b1;
        if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
        else          bus.m_rdata     = mem[bus.m_addr];
      end else begin
        bus.m_ack = 1'b0;
        wait_left--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic issue_i(input logic [AW-1:0] a);
    bus.i_req  = 1'b1;
    bus.i_addr = a;
    i_exp_q.push_back({1'b0, ref_mem[a]});
  endtask

  task automatic issue_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic tmo);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    if (tmo) begin
      d_exp_q.push_back({1'b1, d_last});
    end else if (we) begin
      d_exp_q.push_back({1'b0, d_last});
      ref_mem[a] = wd;
    end else begin
      d_last = ref_mem[a];
      d_exp_q.push_back({1'b0, d_last});
    end
  endtask

  task automatic wait_done(input bit is_d);
    int n;
    n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while (!(is_d ? bus.d_done : bus.i_done) && n < 100);
    if (!(is_d ? bus.d_done : bus.i_done)) begin
      checks++;
      errors++;
      $display("FAIL %s_done_wait: no done pulse within 100 cycles", is_d ? "d" : "i");
    end
    step();
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    issue_i(a);
    wait_done(1'b0);
    bus.i_req = 1'b0;
  endtask

  task automatic dop(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic tmo);
    issue_d(we, a, wd, tmo);
    wait_done(1'b1);
    bus.d_req = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          pend, pend_owner, pend_err, cur_owner, exp_owner;
  logic          prev_mreq, prev_i, prev_d, prev_dwe;
  logic [AW-1:0] prev_ia, prev_da;
  logic [DW-1:0] prev_dwd;
  logic [DW+AW:0] cap;
  int            acc, run;

  initial begin : monitor
    pend = 1'b0; pend_owner = 1'b0; pend_err = 1'b0; cur_owner = 1'b0;
    prev_mreq = 1'b0; prev_i = 1'b0; prev_d = 1'b0; acc = 0; run = 0;
    forever begin
      @(negedge clk1);
      if (!rst_n) begin
        pend = 1'b0; prev_mreq = 1'b0; prev_i = 1'b0; prev_d = 1'b0;
        acc = 0; run = 0; d_last = '0;
        i_exp_q.delete();
        d_exp_q.delete();
        continue;
      end
      // completion: exactly one cycle after ack or timeout, from the granted port only
      if (pend || bus.i_done || bus.d_done || bus.err) begin
        check("i_done", 64'(bus.i_done), 64'(pend && !pend_owner));
        check("d_done", 64'(bus.d_done), 64'(pend && pend_owner));
        check("err", 64'(bus.err), 64'(pend && pend_err));
        if (pend) check("m_req_drop", 64'(bus.m_req), 64'd0);
      end
      if (bus.i_done) begin
        done_log.push_back(cyc);
        if (i_exp_q.size() == 0) check("i_unexpected", 64'(bus.i_done), 64'd0);
        else check("i_rdata", 64'({bus.err, bus.i_rdata}), 64'(i_exp_q.pop_front()));
      end
      if (bus.d_done) begin
        done_log.push_back(cyc);
        if (d_exp_q.size() == 0) check("d_unexpected", 64'(bus.d_done), 64'd0);
        else check("d_rdata", 64'({bus.err, bus.d_rdata}), 64'(d_exp_q.pop_front()));
      end
      pend = 1'b0;
      // grant: decided from the requests seen during the preceding idle cycle
      if (bus.m_req && !prev_mreq) begin
        if (prev_i && prev_d) exp_owner = (run == STARVE_MAX) ? 1'b0 : 1'b1;
        else                  exp_owner = prev_d;
        check("req_seen", 64'(prev_i || prev_d), 64'd1);
        check("owner_d", 64'(bus.owner_d), 64'(exp_owner));
        check("m_addr", 64'(bus.m_addr), 64'(exp_owner ? prev_da : prev_ia));
        check("m_we", 64'(bus.m_we), 64'(exp_owner && prev_dwe));
        if (exp_owner && prev_dwe) check("m_wdata", 64'(bus.m_wdata), 64'(prev_dwd));
        if (!exp_owner)  run = 0;
        else if (prev_i) run = (run < STARVE_MAX) ? run + 1 : run;
        grant_log.push_back(bus.owner_d);
        cur_owner = exp_owner;
        cap = {bus.m_we, bus.m_addr, bus.m_wdata};
        acc = 0;
      end else if (bus.m_req) begin
        check("m_stable", 64'({bus.m_we, bus.m_addr, bus.m_wdata}), 64'(cap));
      end
      if (bus.m_req) begin
        acc++;
        if (bus.m_ack) begin
          pend = 1'b1; pend_err = 1'b0;
        end else if (acc == TIMEOUT) begin
          pend = 1'b1; pend_err = 1'b1;
        end
        if (pend) begin
          pend_owner   = cur_owner;
          last_acc_len = acc;
          last_err     = pend_err;
        end
      end
      prev_mreq = bus.m_req;
      prev_i    = bus.i_req;
      prev_d    = bus.d_req;
      prev_ia   = bus.i_addr;
      prev_da   = bus.d_addr;
      prev_dwe  = bus.d_we;
      prev_dwd  = bus.d_wdata;
    end
  end

  // ---------------- main sequence ----------------
  logic exp_order [6];
  int   t0;

  initial begin : main_seq
    for (int k = 0; k < DEPTH; k++) begin
      mem[k]     = $urandom;
      ref_mem[k] = mem[k];
    end
    mem[0]      = 32'h2801000a;
    ref_mem[0]  = 32'h2801000a;
    d_last      = '0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    check("rst_flags", 64'({bus.i_done, bus.d_done, bus.err, bus.owner_d, bus.m_req, bus.m_we}), 64'd0);
    check("rst_m_addr", 64'(bus.m_addr), 64'd0);
    check("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
    check("rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: single fetch, ack one cycle after m_req
    resp_mode = 0; wait_min = 0; wait_max = 0;
    done_log.delete();
    t0 = cyc;
    fetch(10'd0);
    check("t1_done_count", 64'(done_log.size()), 64'd1);
    if (done_log.size() == 1) check("t1_latency", 64'(done_log[0] - t0), 64'd2);
    check("t1_i_rdata", 64'(bus.i_rdata), 64'h2801000a);

    // 2: both ports held, immediate ack -> D,D,I,D,D,I
    grant_log.delete();
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    fork
      begin
        fetch(10'd3);
        fetch(10'd4);
      end
      begin
        for (int k = 0; k < 4; k++) dop(1'b0, 10'(600 + k), '0, 1'b0);
      end
    join
    check("t2_grant_count", 64'(grant_log.size()), 64'd6);
    if (grant_log.size() == 6)
      for (int k = 0; k < 6; k++) check("t2_grant_order", 64'(grant_log[k]), 64'(exp_order[k]));

    // 3: store with three wait states
    wait_min = 3; wait_max = 3;
    dop(1'b1, 10'd5, 32'h1E, 1'b0);
    check("t3_access_len", 64'(last_acc_len), 64'd4);
    check("t3_mem_written", 64'(mem[5]), 64'h1E);

    // 4: load with no ack -> timeout after TIMEOUT access cycles
    resp_mode = 1;
    dop(1'b0, 10'd700, '0, 1'b1);
    check("t4_access_len", 64'(last_acc_len), 64'(TIMEOUT));
    check("t4_err", 64'(last_err), 64'd1);

    // 5: reset in the middle of a contended data access
    resp_mode = 0; wait_min = 3; wait_max = 3;
    issue_i(10'd10);
    issue_d(1'b0, 10'd610, '0, 1'b0);
    wait_done(1'b1);
    issue_d(1'b0, 10'd611, '0, 1'b0);
    t0 = 0;
    do begin
      @(negedge clk1);
      t0++;
    end while (!bus.m_req && t0 < 20);
    check("t5_m_req_seen", 64'(bus.m_req), 64'd1);
    @(posedge clk1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_m_req", 64'(bus.m_req), 64'd0);
    check("t5_no_done", 64'({bus.i_done, bus.d_done, bus.err}), 64'd0);
    check("t5_d_rdata_clr", 64'(bus.d_rdata), 64'd0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    grant_log.delete();
    fork
      fetch(10'd20);
      dop(1'b0, 10'd612, '0, 1'b0);
    join
    check("t5_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) check("t5_first_grant_d", 64'(grant_log[0]), 64'd1);

    // 6: ack tied high, five back-to-back loads
    resp_mode = 2;
    done_log.delete();
    for (int k = 0; k < 5; k++) dop(1'b0, 10'(800 + k), '0, 1'b0);
    check("t6_done_count", 64'(done_log.size()), 64'd5);
    for (int k = 1; k < done_log.size(); k++)
      check("t6_done_spacing", 64'(done_log[k] - done_log[k-1]), 64'd3);

    // random traffic on both ports with random wait states
    resp_mode = 0; wait_min = 0; wait_max = 4;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(3, 0)) step();
          fetch(AW'($urandom_range(511, 0)));
        end
      end
      begin
        logic          r_we;
        logic [AW-1:0] r_a;
        logic [DW-1:0] r_wd;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(3, 0)) step();
          r_we = 1'($urandom_range(1, 0));
          r_a  = AW'(512 + $urandom_range(15, 0));
          r_wd = $urandom;
          dop(r_we, r_a, r_wd, 1'b0);
        end
      end
    join
    repeat (5) step();
    check("end_i_queue_empty", 64'(i_exp_q.size()), 64'd0);
    check("end_d_queue_empty", 64'(d_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
